collision_scheduler: RTL
========================

// Module: collision_scheduler
// PURPOSE
//  Per-frame sequencer for one shared do_collision engine. Walks every car node through every obstacle in order.
//  For each node it: reads node state, issues one engine job per obstacle, chains post-collision state between jobs, and writes the final state back.
//  Sits between the physics-step controller (frame_start/frame_done) and the node state RAM plus the engine.
// PARAMETERS
//  POSITION_SIZE  8   signed position / displacement width
//  VELOCITY_SIZE  8   signed velocity width
//  DT             1   integer timestep; dx = vx*DT, dy = vy*DT, truncated to POSITION_SIZE
//  NUM_NODES      8   car nodes per frame (>=1)
//  NUM_OBSTACLES  4   obstacles per node (>=1)
//  TIMEOUT        64  max cycles to wait for eng_result_in before aborting the job
// PORTS
//  clk_in          in   1    clock
//  rst_in          in   1    synchronous active-high reset
//  frame_start_in  in   1    1-cycle pulse; starts a frame (ignored unless IDLE)
//  frame_done_out  out  1    1-cycle pulse when all nodes have been written back
//  busy_out        out  1    high from accepted frame_start until frame_done
//  node_addr_out   out  $clog2(NUM_NODES)  node RAM address (read and write)
//  node_rd_out     out  1    read strobe; data valid exactly 1 cycle later
//  node_x_in, node_y_in    in  POSITION_SIZE  node position read data
//  node_vx_in, node_vy_in  in  VELOCITY_SIZE  node velocity read data
//  node_we_out     out  1    write strobe; node_*_out valid the same cycle
//  node_x_out, node_y_out    out  POSITION_SIZE  written position
//  node_vx_out, node_vy_out  out  VELOCITY_SIZE  written velocity
//  obs_sel_out     out  $clog2(NUM_OBSTACLES)  obstacle index; external mux feeds engine obstacle_in
//  eng_begin_out   out  1    1-cycle job start pulse
//  eng_pos_x_out, eng_pos_y_out, eng_dx_out, eng_dy_out  out  POSITION_SIZE  job inputs
//  eng_vx_out, eng_vy_out  out  VELOCITY_SIZE  job inputs
//  eng_result_in   in   1    engine done pulse (result_out)
//  eng_was_coll_in in   1    engine was_collision, sampled with eng_result_in
//  eng_x_new_in, eng_y_new_in, eng_x_int_in, eng_y_int_in  in  POSITION_SIZE
//  eng_vx_new_in, eng_vy_new_in  in  VELOCITY_SIZE
//  coll_count_out  out  16   collisions in the last completed frame
//  timeout_out     out  1    sticky; set on any engine timeout, cleared by frame_start
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0, including strobes, counters and obs_sel/node_addr.
//  FSM states and transitions:
//   IDLE -> READ on frame_start_in. Clear node/obstacle indices, frame collision counter and timeout_out.
//   READ: assert node_rd_out for 1 cycle -> LOAD.
//   LOAD: latch pos, vel; dx = vx*DT, dy = vy*DT; moved = 0 -> ISSUE.
//   ISSUE: eng_begin_out = 1 for 1 cycle, with eng_* outputs and obs_sel_out stable from this cycle until the result -> WAIT.
//   WAIT, on eng_result_in:
//    - if eng_was_coll_in: pos = int; vel = vel_new; dx = x_new - x_int; dy = y_new - y_int; moved = 1; collision counter +1 (saturating).
//    - then if last obstacle -> WRITE; else obstacle +1 -> ISSUE.
//   WAIT timeout: after TIMEOUT cycles with no result, set timeout_out, keep state unchanged, treat as no collision, advance as above.
//   WRITE: node_we_out = 1 with pos+dx, pos+dy (wrapping add) and vel. Then either last node -> DONE, or node +1, obstacle = 0 -> READ.
//   DONE: frame_done_out = 1, coll_count_out updated, -> IDLE.
//  Latency (no collisions, engine latency L cycles to result): per node 3 + NUM_OBSTACLES*(1+L) cycles; +1 for DONE.
//  Exactly one engine job outstanding; eng_begin_out never asserted outside ISSUE.
//  eng_result_in outside WAIT is ignored. frame_start_in while busy is ignored.
//  Simultaneous eng_result_in and timeout expiry: the result wins, and timeout_out is not set.
//  rst_in mid-frame: immediate return to IDLE, no write strobe issued, no frame_done.
//  All arithmetic is signed two's complement, truncated to port width.
// STRUCTURE
//  squishy_pkg: sched_state_t enum (IDLE, READ, LOAD, ISSUE, WAIT, WRITE, DONE) and COUNT_W = 16.
//  Single module; the timeout counter is inline. The do_collision engine is instantiated by the parent, not here.
// TESTING
//  1 node, 1 obstacle, engine model returns no collision after 3 cycles: node (10,10), v (2,-1)
//    -> write (12,9), v (2,-1); frame_done; coll_count = 0.
//  Collision chain: obstacle 0 returns int (11,10), new (11,8), v (-2,-1); obstacle 1 no collision
//    -> obstacle 1 job gets pos (11,10), d (0,-2), v (-2,-1); write (11,8); coll_count = 1.
//  NUM_NODES = 8, NUM_OBSTACLES = 4, no collisions -> 32 begin pulses; addresses 0..7 each written once, in order.
//  Engine never responds, TIMEOUT = 64 -> each job aborts after 64 cycles; timeout_out = 1; frame still completes.
//  frame_start during busy, and a stray eng_result_in in ISSUE -> both ignored; job count unchanged.
//  rst_in asserted in WAIT -> next cycle IDLE, all outputs 0, no node_we_out.

Source files
------------

// File: rtl/squishy_pkg.sv
// Shared types for the collision scheduler: sequencer state encoding and
// the width of the per-frame collision counter.
package squishy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } sched_state_t;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/collision_scheduler.sv
// Per-frame sequencer for a single shared do_collision engine. Every node is
// read, run through each obstacle in turn (post-collision state chained from
// job to job), then written back with its displacement applied.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for frame_start_in
// READ  | node_rd_out high; RAM data arrives in the following cycle
// LOAD  | latch position/velocity, derive displacement from velocity
// ISSUE | eng_begin_out high for the current obstacle
// WAIT  | waiting for eng_result_in, bounded by the timeout counter
// WRITE | node_we_out high with the final position and velocity
// DONE  | frame_done_out high, collision count published
module collision_scheduler
    import squishy_pkg::*;
#(
    parameter int POSITION_SIZE = 8,
    parameter int VELOCITY_SIZE = 8,
    parameter int DT            = 1,
    parameter int NUM_NODES     = 8,
    parameter int NUM_OBSTACLES = 4,
    parameter int TIMEOUT       = 64,
    localparam int NODE_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1,
    localparam int OBS_W  = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     frame_start_in,
    output logic                     frame_done_out,
    output logic                     busy_out,
    output logic [NODE_W-1:0]        node_addr_out,
    output logic                     node_rd_out,
    input  logic [POSITION_SIZE-1:0] node_x_in,
    input  logic [POSITION_SIZE-1:0] node_y_in,
    input  logic [VELOCITY_SIZE-1:0] node_vx_in,
    input  logic [VELOCITY_SIZE-1:0] node_vy_in,
    output logic                     node_we_out,
    output logic [POSITION_SIZE-1:0] node_x_out,
    output logic [POSITION_SIZE-1:0] node_y_out,
    output logic [VELOCITY_SIZE-1:0] node_vx_out,
    output logic [VELOCITY_SIZE-1:0] node_vy_out,
    output logic [OBS_W-1:0]         obs_sel_out,
    output logic                     eng_begin_out,
    output logic [POSITION_SIZE-1:0] eng_pos_x_out,
    output logic [POSITION_SIZE-1:0] eng_pos_y_out,
    output logic [POSITION_SIZE-1:0] eng_dx_out,
    output logic [POSITION_SIZE-1:0] eng_dy_out,
    output logic [VELOCITY_SIZE-1:0] eng_vx_out,
    output logic [VELOCITY_SIZE-1:0] eng_vy_out,
    input  logic                     eng_result_in,
    input  logic                     eng_was_coll_in,
    input  logic [POSITION_SIZE-1:0] eng_x_new_in,
    input  logic [POSITION_SIZE-1:0] eng_y_new_in,
    input  logic [POSITION_SIZE-1:0] eng_x_int_in,
    input  logic [POSITION_SIZE-1:0] eng_y_int_in,
    input  logic [VELOCITY_SIZE-1:0] eng_vx_new_in,
    input  logic [VELOCITY_SIZE-1:0] eng_vy_new_in,
    output logic [COUNT_W-1:0]       coll_count_out,
    output logic                     timeout_out
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    sched_state_t             state;
    logic [TMR_W-1:0]         timer;
    logic [COUNT_W-1:0]       coll_frame;

    logic                     coll_hit;
    logic                     last_obs;
    logic                     last_node;
    logic [POSITION_SIZE-1:0] dx_load;
    logic [POSITION_SIZE-1:0] dy_load;
    logic [POSITION_SIZE-1:0] nxt_pos_x;
    logic [POSITION_SIZE-1:0] nxt_pos_y;
    logic [POSITION_SIZE-1:0] nxt_dx;
    logic [POSITION_SIZE-1:0] nxt_dy;
    logic [VELOCITY_SIZE-1:0] nxt_vx;
    logic [VELOCITY_SIZE-1:0] nxt_vy;

    // Displacement from velocity at node load, and the state that the
    // current job hands on (collision result, or unchanged on miss/timeout).
    always_comb begin
        dx_load   = POSITION_SIZE'($signed(node_vx_in) * DT);
        dy_load   = POSITION_SIZE'($signed(node_vy_in) * DT);
        coll_hit  = eng_result_in && eng_was_coll_in;
        nxt_pos_x = coll_hit ? eng_x_int_in : eng_pos_x_out;
        nxt_pos_y = coll_hit ? eng_y_int_in : eng_pos_y_out;
        nxt_dx    = coll_hit ? (eng_x_new_in - eng_x_int_in) : eng_dx_out;
        nxt_dy    = coll_hit ? (eng_y_new_in - eng_y_int_in) : eng_dy_out;
        nxt_vx    = coll_hit ? eng_vx_new_in : eng_vx_out;
        nxt_vy    = coll_hit ? eng_vy_new_in : eng_vy_out;
        last_obs  = (obs_sel_out == OBS_W'(NUM_OBSTACLES - 1));
        last_node = (node_addr_out == NODE_W'(NUM_NODES - 1));
    end

    // Sequencer FSM; every output is a register, strobes default low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            timer          <= '0;
            coll_frame     <= '0;
            frame_done_out <= 1'b0;
            busy_out       <= 1'b0;
            node_addr_out  <= '0;
            node_rd_out    <= 1'b0;
            node_we_out    <= 1'b0;
            node_x_out     <= '0;
            node_y_out     <= '0;
            node_vx_out    <= '0;
            node_vy_out    <= '0;
            obs_sel_out    <= '0;
            eng_begin_out  <= 1'b0;
            eng_pos_x_out  <= '0;
            eng_pos_y_out  <= '0;
            eng_dx_out     <= '0;
            eng_dy_out     <= '0;
            eng_vx_out     <= '0;
            eng_vy_out     <= '0;
            coll_count_out <= '0;
            timeout_out    <= 1'b0;
        end else begin
            node_rd_out    <= 1'b0;
            node_we_out    <= 1'b0;
            eng_begin_out  <= 1'b0;
            frame_done_out <= 1'b0;

            case (state)
                IDLE: begin
                    if (frame_start_in) begin
                        state         <= READ;
                        busy_out      <= 1'b1;
                        node_rd_out   <= 1'b1;
                        node_addr_out <= '0;
                        obs_sel_out   <= '0;
                        coll_frame    <= '0;
                        timeout_out   <= 1'b0;
                    end
                end

                READ: begin
                    state <= LOAD;
                end

                LOAD: begin
                    eng_pos_x_out <= node_x_in;
                    eng_pos_y_out <= node_y_in;
                    eng_vx_out    <= node_vx_in;
                    eng_vy_out    <= node_vy_in;
                    eng_dx_out    <= dx_load;
                    eng_dy_out    <= dy_load;
                    eng_begin_out <= 1'b1;
                    state         <= ISSUE;
                end

                ISSUE: begin
                    timer <= TMR_W'(TIMEOUT - 1);
                    state <= WAIT;
                end

                WAIT: begin
                    if (eng_result_in || (timer == '0)) begin
                        eng_pos_x_out <= nxt_pos_x;
                        eng_pos_y_out <= nxt_pos_y;
                        eng_dx_out    <= nxt_dx;
                        eng_dy_out    <= nxt_dy;
                        eng_vx_out    <= nxt_vx;
                        eng_vy_out    <= nxt_vy;
                        if (coll_hit && (coll_frame != '1)) begin
                            coll_frame <= coll_frame + COUNT_W'(1);
                        end
                        // A result arriving on the expiry cycle still counts.
                        if (!eng_result_in) begin
                            timeout_out <= 1'b1;
                        end
                        if (last_obs) begin
                            node_we_out <= 1'b1;
                            node_x_out  <= nxt_pos_x + nxt_dx;
                            node_y_out  <= nxt_pos_y + nxt_dy;
                            node_vx_out <= nxt_vx;
                            node_vy_out <= nxt_vy;
                            state       <= WRITE;
                        end else begin
                            obs_sel_out   <= obs_sel_out + OBS_W'(1);
                            eng_begin_out <= 1'b1;
                            state         <= ISSUE;
                        end
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end

                WRITE: begin
                    if (last_node) begin
                        frame_done_out <= 1'b1;
                        coll_count_out <= coll_frame;
                        state          <= DONE;
                    end else begin
                        node_addr_out <= node_addr_out + NODE_W'(1);
                        obs_sel_out   <= '0;
                        node_rd_out   <= 1'b1;
                        state         <= READ;
                    end
                end

                DONE: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
